pipe_ctrl: RTL and testbench

Pipeline control for the 5-stage MIPS core. Takes the stall request from hazard detection and adds the stall sources it does not cover: data-memory wait and the multi-cycle multiply/divide unit (MDU). It turns these into per-stage register enables and bubble (flush) controls. It also sequences the MDU busy period, so that HI/LO accessors wait in D until the result is written.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_mdu_seq.sv | 70 +++++++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and default latencies for the pipeline control
//               block (MDU sequencer state encoding, MULT/DIV cycle counts).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

   // MDU sequencer states; BUSY counts down, DONE is the HI/LO write cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mdu_state_t;

   localparam int MUL_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF = 32;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_if
// Description : Stall sources into, and stage enables / bubble controls /
//               MDU status / performance counters out of, pipe_ctrl.
//               master = pipeline side, slave = pipe_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_ctrl_if;
   logic        stall_req;
   logic        mem_waitM;
   logic        mdu_startE;
   logic        mdu_divE;
   logic        hilo_useD;
   logic        enF;
   logic        enD;
   logic        enE;
   logic        enM;
   logic        flushE;
   logic        flushW;
   logic        mdu_busy;
   logic        mdu_done;
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_mdu_cnt;

   modport master (
      output stall_req, mem_waitM, mdu_startE, mdu_divE, hilo_useD,
      input  enF, enD, enE, enM, flushE, flushW, mdu_busy, mdu_done,
      input  perf_stall_cnt, perf_mdu_cnt
   );

   modport slave (
      input  stall_req, mem_waitM, mdu_startE, mdu_divE, hilo_useD,
      output enF, enD, enE, enM, flushE, flushW, mdu_busy, mdu_done,
      output perf_stall_cnt, perf_mdu_cnt
   );
endinterface : pipe_ctrl_if
`default_nettype wire

// File: rtl/pipe_ctrl_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Multiply/divide busy-period sequencer. An accepted start
//               loads (latency-1) into a down-counter; the FSM stays BUSY
//               until the count reaches zero, then spends one DONE cycle
//               (HI/LO write) before returning to IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_start,
   input  logic i_div,
   output logic o_busy,
   output logic o_done
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   mdu_state_t    r_state;
   mdu_state_t    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;

   // state and countdown registers; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // next state / count; a start outside IDLE is ignored
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = BUSY;
               w_cnt_nxt   = i_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
            end
         end
         BUSY: begin
            if (r_cnt == '0) begin
               w_state_nxt = DONE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_busy = (r_state != IDLE);
   assign o_done = (r_state == DONE);

endmodule : mdu_seq
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : 5-stage MIPS pipeline control. Merges hazard-unit stall,
//               data-memory wait and MDU busy into per-stage enables and
//               bubble controls; holds HI/LO accessors in D until the MDU
//               result is written.
//               Optional feature macro: PIPE_PERF_CNT_EN (stall counters).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
   import pipe_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);

   logic w_enF, w_enD, w_enE, w_enM;
   logic w_flushE, w_flushW;
   logic w_start;
   logic w_busy, w_done;
   logic w_hilo_stall;
   logic w_d_stall;

   // E/M only freeze on a memory wait, so a start is taken whenever M advances
   assign w_enM        = ~bus.mem_waitM;
   assign w_start      = bus.mdu_startE & w_enM;
   assign w_hilo_stall = bus.hilo_useD & (w_busy | w_start);
   assign w_d_stall    = bus.stall_req | w_hilo_stall;

   mdu_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_mdu_seq (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_start),
      .i_div   (bus.mdu_divE),
      .o_busy  (w_busy),
      .o_done  (w_done)
   );

   // enable/flush priority: memory wait freezes everything, else D stall bubbles E
   always_comb begin
      w_enF    = 1'b1;
      w_enD    = 1'b1;
      w_enE    = 1'b1;
      w_flushE = 1'b0;
      w_flushW = 1'b0;
      if (bus.mem_waitM) begin
         w_enF    = 1'b0;
         w_enD    = 1'b0;
         w_enE    = 1'b0;
         w_flushW = 1'b1;
      end else if (w_d_stall) begin
         w_enF    = 1'b0;
         w_enD    = 1'b0;
         w_flushE = 1'b1;
      end
   end

   assign bus.enF      = w_enF;
   assign bus.enD      = w_enD;
   assign bus.enE      = w_enE;
   assign bus.enM      = w_enM;
   assign bus.flushE   = w_flushE;
   assign bus.flushW   = w_flushW;
   assign bus.mdu_busy = w_busy;
   assign bus.mdu_done = w_done;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] r_perf_stall_cnt;
   logic [31:0] r_perf_mdu_cnt;

   // free-running, wrapping stall counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_stall_cnt <= '0;
         r_perf_mdu_cnt   <= '0;
      end else begin
         if (!w_enF) begin
            r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
         end
         if (w_hilo_stall && !bus.mem_waitM) begin
            r_perf_mdu_cnt <= r_perf_mdu_cnt + 32'd1;
         end
      end
   end

   assign bus.perf_stall_cnt = r_perf_stall_cnt;
   assign bus.perf_mdu_cnt   = r_perf_mdu_cnt;
`else
   assign bus.perf_stall_cnt = 32'd0;
   assign bus.perf_mdu_cnt   = 32'd0;
`endif

endmodule : pipe_ctrl
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl. Each cycle the reference
//               model's expectation is queued when inputs are driven and
//               compared against the DUT at the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

   localparam int MUL = 4;
   localparam int DIV = 32;

   typedef struct {
      logic        enF, enD, enE, enM, flushE, flushW, busy, done;
      logic [31:0] pst, pmd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pipe_ctrl_if bus ();

   pipe_ctrl #(
      .MUL_CYCLES (MUL),
      .DIV_CYCLES (DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          m_state = 0;     // 0 idle, 1 busy, 2 done
   int          m_rem   = 0;     // busy cycles still to run
   logic [31:0] m_pst   = 0;
   logic [31:0] m_pmd   = 0;
   logic [31:0] pmd0;

   // a new MDU start must never reach the sequencer while it is occupied
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.mdu_startE && bus.enM && bus.mdu_busy))
            else $error("mdu start issued while sequencer occupied");
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_rem   = 0;
      m_pst   = 0;
      m_pmd   = 0;
   endtask

   // one clock cycle: drive, predict, compare at negedge, advance model at posedge
   task automatic step(input logic s, input logic m, input logic st,
                       input logic dv, input logic u);
      exp_t e;
      logic busy, hilo, dst;
      bus.stall_req  = s;
      bus.mem_waitM  = m;
      bus.mdu_startE = st;
      bus.mdu_divE   = dv;
      bus.hilo_useD  = u;
      busy     = (m_state != 0);
      hilo     = u && (busy || (st && !m));
      dst      = s || hilo;
      e.enF    = !m && !dst;
      e.enD    = !m && !dst;
      e.enE    = !m;
      e.enM    = !m;
      e.flushE = !m && dst;
      e.flushW = m;
      e.busy   = busy;
      e.done   = (m_state == 2);
      e.pst    = m_pst;
      e.pmd    = m_pmd;
      sb.push_back(e);

      @(negedge clk);
      e = sb.pop_front();
      chk("enF",    32'(bus.enF),    32'(e.enF));
      chk("enD",    32'(bus.enD),    32'(e.enD));
      chk("enE",    32'(bus.enE),    32'(e.enE));
      chk("enM",    32'(bus.enM),    32'(e.enM));
      chk("flushE", 32'(bus.flushE), 32'(e.flushE));
      chk("flushW", 32'(bus.flushW), 32'(e.flushW));
      chk("busy",   32'(bus.mdu_busy), 32'(e.busy));
      chk("done",   32'(bus.mdu_done), 32'(e.done));
      chk("perf_stall", bus.perf_stall_cnt, e.pst);
      chk("perf_mdu",   bus.perf_mdu_cnt,   e.pmd);

`ifdef PIPE_PERF_CNT_EN
      if (!e.enF)       m_pst = m_pst + 1;
      if (hilo && !m)   m_pmd = m_pmd + 1;
`endif
      if (m_state == 2) begin
         m_state = 0;
      end else if (m_state == 1) begin
         m_rem = m_rem - 1;
         if (m_rem == 0) m_state = 2;
      end else if (st && !m) begin
         m_state = 1;
         m_rem   = dv ? DIV : MUL;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b1;
      bus.stall_req  = 1'b0;
      bus.mem_waitM  = 1'b0;
      bus.mdu_startE = 1'b0;
      bus.mdu_divE   = 1'b0;
      bus.hilo_useD  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // reset state
      chk("rst_busy",   32'(bus.mdu_busy), 32'd0);
      chk("rst_done",   32'(bus.mdu_done), 32'd0);
      chk("rst_enF",    32'(bus.enF),      32'd1);
      chk("rst_enM",    32'(bus.enM),      32'd1);
      chk("rst_flushE", 32'(bus.flushE),   32'd0);
      chk("rst_flushW", 32'(bus.flushW),   32'd0);
      chk("rst_pst",    bus.perf_stall_cnt, 32'd0);
      chk("rst_pmd",    bus.perf_mdu_cnt,   32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();

      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // single-cycle hazard stall
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
      chk("stall_cnt_one", bus.perf_stall_cnt, 32'd1);
`else
      chk("stall_cnt_one", bus.perf_stall_cnt, 32'd0);
`endif

      // MULT with a HI/LO consumer waiting behind it in D
      pmd0 = m_pmd;
      step(0, 0, 1, 0, 1);
      repeat (6) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0);
`ifdef PIPE_PERF_CNT_EN
      chk("mult_hilo_cycles", bus.perf_mdu_cnt, pmd0 + 32'd6);
`else
      chk("mult_hilo_cycles", bus.perf_mdu_cnt, 32'd0);
`endif
      repeat (2) step(0, 0, 0, 0, 0);

      // DIV held in E by a memory wait, stall_req overlapped in one cycle
      step(0, 1, 1, 1, 0);
      step(1, 1, 1, 1, 0);
      step(0, 1, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      repeat (DIV + 3) step(0, 0, 0, 0, 0);

      // reset in the fifth BUSY cycle of a DIV
      step(0, 0, 1, 1, 0);
      repeat (4) step(0, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.mdu_busy), 32'd0);
      chk("arst_done", 32'(bus.mdu_done), 32'd0);
      chk("arst_enF",  32'(bus.enF),      32'd1);
      chk("arst_pst",  bus.perf_stall_cnt, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      repeat (DIV + 4) step(0, 0, 0, 0, 0);

      // short MULT with random side stalls
      step(0, 0, 1, 0, 1);
      for (int i = 0; i < 8; i++) begin
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      repeat (2) step(0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_pipe_ctrl
`default_nettype wire
